// File: rtl/core_ctrl.sv
// core_ctrl: multi-cycle CPU control FSM; define CORE_CTRL_TIMEOUT_EN to add the memory-timeout fault
module core_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] instr_i,
  input  logic        mem_ready_i,
  input  logic [2:0]  alu_flag_i,
  output logic        en_rf_o,
  output logic        we_rf_o,
  output logic        sel_rf_o,
  output logic        en_pc_o,
  output logic        load_pc_o,
  output logic        rstn_pc_o,
  output logic        we_ir_o,
  output logic        load_addr_reg_o,
  output logic        sel_alu_port_a_o,
  output logic        sel_alu_port_b_o,
  output logic [2:0]  alu_op_o,
  output logic        re_mem_o,
  output logic        we_mem_o,
  output logic [31:0] imm_o,
  output logic [4:0]  rf_addr_a_o,
  output logic [4:0]  rf_addr_b_o,
  output logic        halt_o,
  output logic        err_o
);
  typedef enum logic [3:0] {FETCH, FETCH_W, DECODE, EXEC, BR, MEM, MEM_W, WB, HALT, FAULT} state_t;
  state_t state, next;
  logic [3:0] op;
  logic flag, tout, rb_zero;
  logic en_rf, we_rf, sel_rf, en_pc, load_pc, we_ir, load_addr, sel_a, sel_b, re, we, halt, err;
  logic [2:0] alu_op;
  logic unused_flags;
  assign op = instr_i[31:28];
  assign unused_flags = ^alu_flag_i[2:1];
`ifdef CORE_CTRL_TIMEOUT_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] cnt;
  logic wait_st;
  assign wait_st = (state == FETCH_W) || (state == MEM_W);
  assign tout = cnt == CW'(MEM_TIMEOUT - 1);
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt <= '0;
    else cnt <= (!wait_st || next != state) ? '0 : (cnt == CW'(MEM_TIMEOUT)) ? cnt : cnt + 1'b1;
`else
  localparam int unused_timeout = MEM_TIMEOUT;
  assign tout = 1'b0;
`endif
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= FETCH;
      flag  <= 1'b0;
    end else begin
      state <= next;
      if (state == EXEC) flag <= alu_flag_i[0];
    end
  always_comb begin
    next = state;
    {en_rf, we_rf, sel_rf, en_pc, load_pc, we_ir, load_addr, sel_a, sel_b, re, we, halt, err, rb_zero} = '0;
    alu_op = 3'b000;
    case (state)
      FETCH: begin
        re   = 1'b1;
        next = FETCH_W;
      end
      FETCH_W: begin
        re    = 1'b1;
        we_ir = mem_ready_i;
        en_pc = mem_ready_i;
        next  = mem_ready_i ? DECODE : tout ? FAULT : FETCH_W;
      end
      DECODE: begin
        en_rf = 1'b1;
        next  = (op == 4'd0 || (op >= 4'd7 && op <= 4'd14)) ? FETCH : (op == 4'd15) ? HALT : EXEC;
      end
      EXEC: begin
        en_rf = 1'b1;
        case (op)
          4'd1: begin
            alu_op = instr_i[2:0];
            next   = WB;
          end
          4'd2, 4'd3, 4'd4: begin
            sel_b     = 1'b1;
            load_addr = op != 4'd2;
            next      = (op == 4'd2) ? WB : MEM;
          end
          4'd5: begin
            rb_zero = 1'b1;
            alu_op  = 3'b001;
            next    = BR;
          end
          4'd6: begin
            sel_a   = 1'b1;
            sel_b   = 1'b1;
            load_pc = 1'b1;
            next    = FETCH;
          end
          default: next = FETCH;
        endcase
      end
      BR: begin
        sel_a   = 1'b1;
        sel_b   = 1'b1;
        load_pc = flag;
        next    = FETCH;
      end
      MEM: begin
        re   = op == 4'd3;
        we   = op == 4'd4;
        next = MEM_W;
      end
      MEM_W: begin
        re   = op == 4'd3;
        we   = op == 4'd4;
        next = mem_ready_i ? ((op == 4'd3) ? WB : FETCH) : tout ? FAULT : MEM_W;
      end
      WB: begin
        en_rf  = 1'b1;
        we_rf  = 1'b1;
        sel_rf = op == 4'd3;
        next   = FETCH;
      end
      HALT: halt = 1'b1;
      FAULT: begin
        halt = 1'b1;
        err  = 1'b1;
      end
      default: next = FETCH;
    endcase
  end
  // Every output is forced low while reset is held, including the field decode.
  assign en_rf_o          = en_rf & ~rst_i;
  assign we_rf_o          = we_rf & ~rst_i;
  assign sel_rf_o         = sel_rf & ~rst_i;
  assign en_pc_o          = en_pc & ~rst_i;
  assign load_pc_o        = load_pc & ~rst_i;
  assign rstn_pc_o        = ~rst_i;
  assign we_ir_o          = we_ir & ~rst_i;
  assign load_addr_reg_o  = load_addr & ~rst_i;
  assign sel_alu_port_a_o = sel_a & ~rst_i;
  assign sel_alu_port_b_o = sel_b & ~rst_i;
  assign alu_op_o         = rst_i ? 3'b000 : alu_op;
  assign re_mem_o         = re & ~rst_i;
  assign we_mem_o         = we & ~rst_i;
  assign halt_o           = halt & ~rst_i;
  assign err_o            = err & ~rst_i;
  assign imm_o            = rst_i ? 32'h0 : {{14{instr_i[17]}}, instr_i[17:0]};
  assign rf_addr_a_o      = rst_i ? 5'd0 : instr_i[27:23];
  assign rf_addr_b_o      = (rst_i || rb_zero) ? 5'd0 : instr_i[22:18];
endmodule
